// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and frame constants for fifo_uart_tx (UART_PARITY_EN adds the parity bit)
package uart_pkg;
    localparam int DATA_W = 8;
`ifdef UART_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif
    localparam int FRAME_HDR_BITS = 1 + DATA_W + PARITY_BITS;
    typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} state_t;
    function automatic int frame_bits(input int stop_bits);
        return FRAME_HDR_BITS + stop_bits;
    endfunction
endpackage

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if: FIFO read-port handshake between a byte FIFO (slave) and its UART drain stage (master)
interface fifo_uart_tx_if;
    import uart_pkg::*;
    logic              fifo_empty;
    logic              fifo_wr_busy;
    logic              fifo_rd;
    logic [DATA_W-1:0] fifo_data;
    modport master (output fifo_rd, input fifo_empty, fifo_data, fifo_wr_busy);
    modport slave  (input fifo_rd, output fifo_empty, fifo_data, fifo_wr_busy);
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: per-bit cycle counter with synchronous clear; o_tick marks the last cycle of a bit
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);
    localparam int W = $clog2(CLKS_PER_BIT + 1);
    logic [W-1:0] r_cnt;
    assign o_tick = r_cnt == W'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk)
        r_cnt <= (rst || i_clr || o_tick) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a FIFO and serialises them as UART frames; UART_PARITY_EN adds a parity bit
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
`ifdef UART_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.master io_fifo,
    output logic           o_tx,
    output logic           o_busy
);
    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_shift;
    logic [2:0]        r_idx;
    logic              w_tick;
`ifdef UART_PARITY_EN
    logic              r_par;
`endif
    uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst   (rst),
        .i_clr (r_state == LOAD),
        .o_tick(w_tick)
    );
    always_ff @(posedge clk)
        r_state <= rst ? IDLE : w_next;
    always_comb begin
        w_next = r_state;
        o_tx   = 1'b1;
        case (r_state)
            IDLE:    w_next = io_fifo.fifo_empty ? IDLE : POP;
            POP:     w_next = io_fifo.fifo_wr_busy ? POP : LOAD;
            LOAD:    w_next = START;
            START: begin
                o_tx   = 1'b0;
                w_next = w_tick ? DATA : START;
            end
`ifdef UART_PARITY_EN
            DATA: begin
                o_tx   = r_shift[0];
                w_next = (w_tick && r_idx == 3'd7) ? PARITY : DATA;
            end
            PARITY: begin
                o_tx   = r_par ^ PARITY_ODD;
                w_next = w_tick ? STOP : PARITY;
            end
`else
            DATA: begin
                o_tx   = r_shift[0];
                w_next = (w_tick && r_idx == 3'd7) ? STOP : DATA;
            end
`endif
            STOP:    w_next = (w_tick && r_idx == 3'(STOP_BITS - 1)) ? IDLE : STOP;
            default: w_next = IDLE;
        endcase
    end
    assign io_fifo.fifo_rd = r_state == POP;
    assign o_busy          = r_state != IDLE;
    // r_idx wraps 7->0 leaving DATA, then counts stop bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (r_state == LOAD) begin
            r_shift <= io_fifo.fifo_data;
            r_idx   <= '0;
        end else if (w_tick && r_state == DATA) begin
            r_shift <= r_shift >> 1;
            r_idx   <= r_idx + 1'b1;
        end else if (w_tick && r_state == STOP) begin
            r_idx   <= (w_next == IDLE) ? '0 : r_idx + 1'b1;
        end
    end
`ifdef UART_PARITY_EN
    always_ff @(posedge clk)
        if (rst || r_state == LOAD) r_par <= 1'b0;
        else if (w_tick && r_state == DATA) r_par <= r_par ^ r_shift[0];
`endif
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: two lanes (STOP_BITS 1 and 2) checked cycle by cycle against a frame-level reference
module tb_fifo_uart_tx;
    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       push      = 1'b0;
    logic [7:0] push_data = '0;
    int         n_checks  = 0;
    int         n_errors  = 0;
    int         n_push    = 0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic frame_bit(input logic [7:0] b, input int i, input bit odd);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i - 1];
        if (PAR == 1 && i == 9) return ^b ^ odd;
        return 1'b1;
    endfunction
    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int SB   = g + 1;
        localparam int FLEN = (1 + 8 + PAR + SB) * CPB;
        fifo_uart_tx_if bus ();
        logic       tx, busy;
        logic [7:0] q[$];
        logic [7:0] sb[$];
        logic [7:0] cur = '0;
        int ph = 0, k = 0, frames = 0, dropped = 0, rd_cycles = 0;
        fifo_uart_tx #(
            .CLKS_PER_BIT(CPB),
            .STOP_BITS   (SB)
`ifdef UART_PARITY_EN
            ,
            .PARITY_ODD  (g == 1)
`endif
        ) dut (
            .clk    (clk),
            .rst    (rst),
            .io_fifo(bus),
            .o_tx   (tx),
            .o_busy (busy)
        );
        assign bus.fifo_wr_busy = push;
        always @(posedge clk) begin
            if (bus.fifo_rd && !push && q.size() > 0) bus.fifo_data <= q.pop_front();
            if (push) begin
                q.push_back(push_data);
                sb.push_back(push_data);
            end
            bus.fifo_empty <= q.size() == 0;
        end
        // ph: 0 idle, 1 popping, 2 load, 3 frame (k = cycle within frame)
        always @(negedge clk) begin
            check($sformatf("lane%0d tx", g), tx, ph == 3 ? frame_bit(cur, k / CPB, g == 1) : 1'b1);
            check($sformatf("lane%0d busy", g), busy, ph != 0);
            check($sformatf("lane%0d rd", g), bus.fifo_rd, ph == 1);
            if (bus.fifo_rd) rd_cycles++;
            if (ph == 1 && !push) cur = sb.pop_front();
            if (rst) begin
                if (ph >= 2 || (ph == 1 && !push)) dropped++;
                ph = 0;
            end else if (ph == 0) ph = bus.fifo_empty ? 0 : 1;
            else if (ph == 1) ph = push ? 1 : 2;
            else if (ph == 2) begin
                ph = 3;
                k  = 0;
            end else begin
                k++;
                if (k == FLEN) begin
                    ph = 0;
                    frames++;
                end
            end
        end
    end
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic put(input logic [7:0] b);
        push = 1'b1;
        push_data = b;
        n_push++;
        idle(1);
        push = 1'b0;
    endtask
    task automatic drain();
        int t = 0;
        while ((lane[0].busy || lane[1].busy || !lane[0].bus.fifo_empty || !lane[1].bus.fifo_empty) && t < 3000) begin
            idle(1);
            t++;
        end
        check("drain timeout", t < 3000, 1'b1);
        idle(2);
    endtask
    initial begin
        int r0, r1;
        idle(3);
        rst = 1'b0;
        idle(2);
        r0 = lane[0].rd_cycles;
        put(8'hA5);
        drain();
        check("single pop", lane[0].rd_cycles - r0, 1);
        put(8'h00);
        put(8'hFF);
        drain();
        r0 = lane[0].rd_cycles;
        r1 = lane[1].rd_cycles;
        put(8'h3C);
        idle(1);
        put(8'h11);
        put(8'h22);
        drain();
        check("collision rd lane0", lane[0].rd_cycles - r0, 5);
        check("collision rd lane1", lane[1].rd_cycles - r1, 5);
        put(8'h5A);
        idle(20);
        rst = 1'b1;
        idle(1);
        check("reset tx", lane[0].tx, 1'b1);
        check("reset busy", lane[0].busy, 1'b0);
        rst = 1'b0;
        idle(3);
        put(8'h96);
        drain();
        put(8'h07);
        drain();
        r0 = lane[0].rd_cycles;
        r1 = lane[1].rd_cycles;
        idle(100);
        check("empty rd lane0", lane[0].rd_cycles - r0, 0);
        check("empty rd lane1", lane[1].rd_cycles - r1, 0);
        repeat (40) begin
            idle($urandom_range(0, 3) == 0 ? $urandom_range(0, 60) : $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
            end else put(8'($urandom));
        end
        drain();
        idle(5);
        check("lane0 bytes", lane[0].frames + lane[0].dropped, n_push);
        check("lane1 bytes", lane[1].frames + lane[1].dropped, n_push);
        check("lane0 fifo left", lane[0].q.size(), 0);
        check("lane1 fifo left", lane[1].q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
